// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default widths for the multi-context register file
package regfile_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - sequential context clear engine (one register per cycle)
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CTX_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr_req,
  input  logic [CTX_W-1:0]  i_clr_ctx,
  output logic              o_clr_busy,
  output logic              o_clr_done,
  output logic              o_clr_active,
  output logic [CTX_W-1:0]  o_clr_ctx_q,
  output logic [ADDR_W-1:0] o_clr_addr
);

  clr_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [CTX_W-1:0]  r_ctx_q, w_ctx_nxt;
  logic              r_done, w_done_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
      r_ctx_q <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ctx_q <= w_ctx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Register 0 is hardwired, so the sweep starts at 1 and stops at all-ones.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ctx_nxt   = r_ctx_q;
    w_done_nxt  = 1'b0;
    case (r_state)
      CLR_IDLE: begin
        if (i_clr_req) begin
          w_ctx_nxt   = i_clr_ctx;
          w_cnt_nxt   = ADDR_W'(1);
          w_state_nxt = CLR_RUN;
        end
      end
      CLR_RUN: begin
        if (&r_cnt) begin
          w_state_nxt = CLR_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = CLR_IDLE;
    endcase
  end

  assign o_clr_active = (r_state == CLR_RUN);
  assign o_clr_busy   = (r_state == CLR_RUN);
  assign o_clr_done   = r_done;
  assign o_clr_ctx_q  = r_ctx_q;
  assign o_clr_addr   = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-context register file, NUM_RD combinational reads with bypass, NUM_WR writes
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int NUM_CTX = 4,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  localparam int CTX_W    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  localparam int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*CTX_W-1:0]  rd_ctx,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*CTX_W-1:0]  wr_ctx,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     clr_req,
  input  logic [CTX_W-1:0]         clr_ctx,
  output logic                     clr_busy,
  output logic                     clr_done
);

  logic [DATA_W-1:0] r_mem [NUM_CTX][NUM_REGS];

  logic              w_clr_active;
  logic [CTX_W-1:0]  w_clr_ctx_q;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_clr_wr;

  logic [NUM_WR-1:0] w_wr_ok;
  logic [CTX_W-1:0]  w_wr_ctx  [NUM_WR];
  logic [ADDR_W-1:0] w_wr_addr [NUM_WR];
  logic [DATA_W-1:0] w_wr_data [NUM_WR];

  regfile_clear_fsm #(
    .ADDR_W (ADDR_W),
    .CTX_W  (CTX_W)
  ) u_clear (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clr_req    (clr_req),
    .i_clr_ctx    (clr_ctx),
    .o_clr_busy   (clr_busy),
    .o_clr_done   (clr_done),
    .o_clr_active (w_clr_active),
    .o_clr_ctx_q  (w_clr_ctx_q),
    .o_clr_addr   (w_clr_addr)
  );

  assign w_clr_wr = w_clr_active && (32'(w_clr_ctx_q) < NUM_CTX);

  // A port is live only for a real context, a nonzero address and a context not being cleared.
  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      w_wr_ctx[p]  = wr_ctx[p*CTX_W +: CTX_W];
      w_wr_addr[p] = wr_addr[p*ADDR_W +: ADDR_W];
      w_wr_data[p] = wr_data[p*DATA_W +: DATA_W];
      w_wr_ok[p]   = wr_en[p] && (32'(w_wr_ctx[p]) < NUM_CTX) && (w_wr_addr[p] != '0) &&
                     !(w_clr_active && (w_wr_ctx[p] == w_clr_ctx_q));
    end
  end

  // Later ports overwrite earlier ones in the loop, giving highest-index priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CTX; c++)
        for (int a = 0; a < NUM_REGS; a++)
          r_mem[c][a] <= '0;
    end else begin
      if (w_clr_wr)
        r_mem[w_clr_ctx_q][w_clr_addr] <= '0;
      for (int p = 0; p < NUM_WR; p++)
        if (w_wr_ok[p])
          r_mem[w_wr_ctx[p]][w_wr_addr[p]] <= w_wr_data[p];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      logic [CTX_W-1:0]  w_ctx;
      logic [ADDR_W-1:0] w_addr;
      w_ctx  = rd_ctx[r*CTX_W +: CTX_W];
      w_addr = rd_addr[r*ADDR_W +: ADDR_W];
      if ((32'(w_ctx) < NUM_CTX) && (w_addr != '0) &&
          !(w_clr_active && (w_ctx == w_clr_ctx_q))) begin
        rd_data[r*DATA_W +: DATA_W] = r_mem[w_ctx][w_addr];
        for (int p = 0; p < NUM_WR; p++)
          if (w_wr_ok[p] && (w_wr_ctx[p] == w_ctx) && (w_wr_addr[p] == w_addr))
            rd_data[r*DATA_W +: DATA_W] = w_wr_data[p];
      end
    end
  end

endmodule
